// File: rtl/rx_ptp_parse.sv
// Receive-side PTPv2-over-Ethernet parser: watches the XGMII rx stream, latches the SFD
// timestamp and PTP header identity fields, and reports qualifying frames with a pulse.
module rx_ptp_parse #(
  parameter logic [15:0] VLAN_TPID = 16'h8100,
  parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
  input  logic         rx_clk,
  input  logic         rx_rst,
  input  logic         rx_clk_en_i,
  input  logic [63:0]  rxd_i,
  input  logic [7:0]   rxc_i,
  input  logic [79:0]  sfd_timestamp_i,
  input  logic [15:0]  sfd_timestamp_frac_ns_i,
  input  logic         rx_ptp_en_i,
  input  logic         event_only_i,
  input  logic         int_clr_i,
  output logic         rxts_valid_o,
  output logic [95:0]  rxts_timestamp_o,
  output logic [79:0]  rx_sourcePortIdentity_o,
  output logic [15:0]  rx_flagField_o,
  output logic [15:0]  rx_seqId_o,
  output logic [3:0]   rx_versionPTP_o,
  output logic [3:0]   rx_minorVersionPTP_o,
  output logic [3:0]   rx_messageType_o,
  output logic [3:0]   rx_majorSdoId_o,
  output logic         int_rx_ptp_o
);

  typedef enum logic [1:0] {StIdle, StHdr, StPtp, StDrop} state_e;

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            vlan_q, vlan_d;
  logic [7:0]      hoff_q, hoff_d;
  logic            hdr_done_q, hdr_done_d;
  logic [95:0]     ts_q, ts_d;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d;
  logic [15:0]     flag_q, flag_d, seq_q, seq_d;
  logic [9:0][7:0] spid_q, spid_d;

  logic            valid_q, int_q;
  logic [95:0]     out_ts_q;
  logic [7:0]      out_b0_q, out_b1_q;
  logic [15:0]     out_flag_q, out_seq_q;
  logic [79:0]     out_spid_q;

  logic            is_start, term, ctrl_err, ptp_now, qualify;
  logic [7:0]      lane_ok;
  logic [7:0]      h_now, off, byte_v;

  assign is_start = (rxc_i == 8'h01) && (rxd_i == 64'hD555_5555_5555_55FB);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vlan_d     = vlan_q;
    hoff_d     = hoff_q;
    hdr_done_d = hdr_done_q;
    ts_d       = ts_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    flag_d     = flag_q;
    seq_d      = seq_q;
    spid_d     = spid_q;
    qualify    = 1'b0;
    ptp_now    = 1'b0;
    h_now      = hoff_q;
    term       = 1'b0;
    ctrl_err   = 1'b0;
    lane_ok    = '0;
    off        = '0;
    byte_v     = '0;

    // Lanes after the terminate are idle fill and are neither data nor errors.
    for (int l = 0; l < 8; l++) begin
      lane_ok[l] = !rxc_i[l] && !term;
      if (!term && rxc_i[l]) begin
        if (rxd_i[8*l +: 8] == 8'hFD) term = 1'b1;
        else ctrl_err = 1'b1;
      end
    end

    if (is_start) begin
      if (rx_ptp_en_i) begin
        state_d    = StHdr;
        cnt_d      = '0;
        vlan_d     = 1'b0;
        hdr_done_d = 1'b0;
        ts_d       = {sfd_timestamp_i, sfd_timestamp_frac_ns_i};
      end else begin
        state_d = StIdle;
      end
    end else if (state_q != StIdle) begin
      if (!rx_ptp_en_i) begin
        state_d = StIdle;
      end else begin
        cnt_d = (cnt_q > 7'd119) ? 7'd127 : cnt_q + 7'd8;
        case (state_q)
          StHdr: begin
            if (cnt_q == 7'd8) begin
              if ({rxd_i[39:32], rxd_i[47:40]} == PTP_ETYPE) begin
                ptp_now = 1'b1;
                h_now   = 8'd14;
              end else if ({rxd_i[39:32], rxd_i[47:40]} == VLAN_TPID) begin
                vlan_d = 1'b1;
              end else begin
                state_d = StDrop;
              end
            end else if (cnt_q == 7'd16 && vlan_q) begin
              if ({rxd_i[7:0], rxd_i[15:8]} == PTP_ETYPE) begin
                ptp_now = 1'b1;
                h_now   = 8'd18;
              end else begin
                state_d = StDrop;
              end
            end
          end
          StPtp:   ptp_now = 1'b1;
          default: ;
        endcase

        if (ptp_now) begin
          state_d = StPtp;
          hoff_d  = h_now;
          // off wraps for lanes before the header start; those never match a field.
          for (int l = 0; l < 8; l++) begin
            off    = {1'b0, cnt_q} + 8'(l) - h_now;
            byte_v = rxd_i[8*l +: 8];
            if (lane_ok[l]) begin
              case (off)
                8'd0:  b0_d = byte_v;
                8'd1:  b1_d = byte_v;
                8'd6:  flag_d[15:8] = byte_v;
                8'd7:  flag_d[7:0] = byte_v;
                8'd30: seq_d[15:8] = byte_v;
                8'd31: begin
                  seq_d[7:0] = byte_v;
                  hdr_done_d = 1'b1;
                end
                default: begin
                  if (off >= 8'd20 && off <= 8'd29) spid_d[4'(8'd29 - off)] = byte_v;
                end
              endcase
            end
          end
        end

        if (ctrl_err) state_d = StDrop;
        if (term) begin
          state_d = StIdle;
          qualify = (state_q == StPtp) && hdr_done_d && !ctrl_err &&
                    (!event_only_i || b0_d[3:0] < 4'd8);
        end
      end
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      vlan_q     <= 1'b0;
      hoff_q     <= '0;
      hdr_done_q <= 1'b0;
      ts_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      flag_q     <= '0;
      seq_q      <= '0;
      spid_q     <= '0;
      valid_q    <= 1'b0;
      int_q      <= 1'b0;
      out_ts_q   <= '0;
      out_b0_q   <= '0;
      out_b1_q   <= '0;
      out_flag_q <= '0;
      out_seq_q  <= '0;
      out_spid_q <= '0;
    end else if (rx_clk_en_i) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vlan_q     <= vlan_d;
      hoff_q     <= hoff_d;
      hdr_done_q <= hdr_done_d;
      ts_q       <= ts_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      flag_q     <= flag_d;
      seq_q      <= seq_d;
      spid_q     <= spid_d;
      valid_q    <= qualify;
      // A set in the same cycle as a clear wins.
      int_q      <= (int_q & ~int_clr_i) | valid_q;
      if (qualify) begin
        out_ts_q   <= ts_q;
        out_b0_q   <= b0_d;
        out_b1_q   <= b1_d;
        out_flag_q <= flag_d;
        out_seq_q  <= seq_d;
        out_spid_q <= spid_d;
      end
    end
  end

  assign rxts_valid_o            = valid_q & rx_clk_en_i;
  assign rxts_timestamp_o        = out_ts_q;
  assign rx_sourcePortIdentity_o = out_spid_q;
  assign rx_flagField_o          = out_flag_q;
  assign rx_seqId_o              = out_seq_q;
  assign rx_versionPTP_o         = out_b1_q[3:0];
  assign rx_minorVersionPTP_o    = out_b1_q[7:4];
  assign rx_messageType_o        = out_b0_q[3:0];
  assign rx_majorSdoId_o         = out_b0_q[7:4];
  assign int_rx_ptp_o            = int_q;

endmodule

// File: tb/tb_rx_ptp_parse.sv
// Directed bench for rx_ptp_parse: builds XGMII frames byte by byte and checks the
// reported PTP fields, pulse count and interrupt behaviour against hand-derived values.
module tb_rx_ptp_parse;

  logic         rx_clk = 1'b0;
  logic         rx_rst;
  logic         rx_clk_en_i;
  logic [63:0]  rxd_i;
  logic [7:0]   rxc_i;
  logic [79:0]  sfd_timestamp_i;
  logic [15:0]  sfd_timestamp_frac_ns_i;
  logic         rx_ptp_en_i;
  logic         event_only_i;
  logic         int_clr_i;
  logic         rxts_valid_o;
  logic [95:0]  rxts_timestamp_o;
  logic [79:0]  rx_sourcePortIdentity_o;
  logic [15:0]  rx_flagField_o;
  logic [15:0]  rx_seqId_o;
  logic [3:0]   rx_versionPTP_o;
  logic [3:0]   rx_minorVersionPTP_o;
  logic [3:0]   rx_messageType_o;
  logic [3:0]   rx_majorSdoId_o;
  logic         int_rx_ptp_o;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int p0;
  bit slow = 1'b0;
  logic [7:0] fb [0:127];

  localparam logic [79:0] Spid1 = 80'h0011_2233_4455_6677_8899;
  localparam logic [79:0] Spid2 = 80'hA1A2_A3A4_A5A6_A7A8_A9AA;

  rx_ptp_parse dut (
    .rx_clk                  (rx_clk),
    .rx_rst                  (rx_rst),
    .rx_clk_en_i             (rx_clk_en_i),
    .rxd_i                   (rxd_i),
    .rxc_i                   (rxc_i),
    .sfd_timestamp_i         (sfd_timestamp_i),
    .sfd_timestamp_frac_ns_i (sfd_timestamp_frac_ns_i),
    .rx_ptp_en_i             (rx_ptp_en_i),
    .event_only_i            (event_only_i),
    .int_clr_i               (int_clr_i),
    .rxts_valid_o            (rxts_valid_o),
    .rxts_timestamp_o        (rxts_timestamp_o),
    .rx_sourcePortIdentity_o (rx_sourcePortIdentity_o),
    .rx_flagField_o          (rx_flagField_o),
    .rx_seqId_o              (rx_seqId_o),
    .rx_versionPTP_o         (rx_versionPTP_o),
    .rx_minorVersionPTP_o    (rx_minorVersionPTP_o),
    .rx_messageType_o        (rx_messageType_o),
    .rx_majorSdoId_o         (rx_majorSdoId_o),
    .int_rx_ptp_o            (int_rx_ptp_o)
  );

  always #5 rx_clk = ~rx_clk;

  always @(negedge rx_clk) if (rxts_valid_o === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    if (slow) begin
      rx_clk_en_i = 1'b0;
      rxd_i = d;
      rxc_i = c;
      repeat (9) @(posedge rx_clk);
      #1;
    end
    rxd_i = d;
    rxc_i = c;
    rx_clk_en_i = 1'b1;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_word(64'h0707_0707_0707_0707, 8'hFF);
  endtask

  // Frame byte 0 is the first DA byte; the terminate sits at byte index len.
  task automatic send_frame(input bit vlan, input logic [15:0] et, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [15:0] flag,
                            input logic [15:0] seq, input logic [79:0] spid, input int len,
                            input int err_idx);
    int p;
    logic [63:0] d;
    logic [7:0] c;
    for (int i = 0; i < 128; i++) fb[i] = 8'(i);
    p = 12;
    if (vlan) begin
      fb[12] = 8'h81; fb[13] = 8'h00; fb[14] = 8'h00; fb[15] = 8'h05;
      p = 16;
    end
    fb[p] = et[15:8];
    fb[p+1] = et[7:0];
    p = p + 2;
    fb[p] = b0;
    fb[p+1] = b1;
    fb[p+6] = flag[15:8];
    fb[p+7] = flag[7:0];
    for (int k = 0; k < 10; k++) fb[p+20+k] = spid[79-8*k -: 8];
    fb[p+30] = seq[15:8];
    fb[p+31] = seq[7:0];
    send_word(64'hD555_5555_5555_55FB, 8'h01);
    for (int w = 0; w <= len / 8; w++) begin
      d = '0;
      c = '0;
      for (int l = 0; l < 8; l++) begin
        if (w*8 + l < len) begin
          if (w*8 + l == err_idx) begin
            c[l] = 1'b1;
            d[8*l +: 8] = 8'hFE;
          end else begin
            d[8*l +: 8] = fb[w*8 + l];
          end
        end else begin
          c[l] = 1'b1;
          d[8*l +: 8] = (w*8 + l == len) ? 8'hFD : 8'h07;
        end
      end
      send_word(d, c);
    end
  endtask

  task automatic test_reset;
    rx_rst = 1'b1;
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++; if (rxts_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", rxts_valid_o); end
    n_checks++; if (int_rx_ptp_o !== 1'b0) begin n_fail++; $display("FAIL reset int: got %b want 0", int_rx_ptp_o); end
    n_checks++; if (rxts_timestamp_o !== 96'h0) begin n_fail++; $display("FAIL reset ts: got %h want 0", rxts_timestamp_o); end
    n_checks++; if (rx_seqId_o !== 16'h0) begin n_fail++; $display("FAIL reset seqId: got %h want 0", rx_seqId_o); end
    n_checks++; if (rx_sourcePortIdentity_o !== 80'h0) begin n_fail++; $display("FAIL reset spid: got %h want 0", rx_sourcePortIdentity_o); end
    rx_rst = 1'b0;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic test_untagged;
    sfd_timestamp_i = 80'h1_0000_0005;
    sfd_timestamp_frac_ns_i = 16'hABCD;
    p0 = pulse_cnt;
    send_frame(1'b0, 16'h88F7, 8'h00, 8'h12, 16'h0200, 16'h1234, Spid1, 59, -1);
    sfd_timestamp_i = 80'hFFFF;
    @(negedge rx_clk);
    n_checks++; if (rxts_valid_o !== 1'b1) begin n_fail++; $display("FAIL untagged latency: valid %b want 1", rxts_valid_o); end
    @(posedge rx_clk); #1;
    send_idle(4);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL untagged pulses: got %0d want 1", pulse_cnt - p0); end
    n_checks++; if (rxts_timestamp_o !== 96'h1_0000_0005_ABCD) begin n_fail++; $display("FAIL untagged ts: got %h want %h", rxts_timestamp_o, 96'h1_0000_0005_ABCD); end
    n_checks++; if (rx_seqId_o !== 16'h1234) begin n_fail++; $display("FAIL untagged seqId: got %h want 1234", rx_seqId_o); end
    n_checks++; if (rx_flagField_o !== 16'h0200) begin n_fail++; $display("FAIL untagged flag: got %h want 0200", rx_flagField_o); end
    n_checks++; if (rx_sourcePortIdentity_o !== Spid1) begin n_fail++; $display("FAIL untagged spid: got %h want %h", rx_sourcePortIdentity_o, Spid1); end
    n_checks++; if (rx_messageType_o !== 4'h0) begin n_fail++; $display("FAIL untagged msgType: got %h want 0", rx_messageType_o); end
    n_checks++; if (rx_versionPTP_o !== 4'h2 || rx_minorVersionPTP_o !== 4'h1) begin n_fail++; $display("FAIL untagged version: got %h.%h want 2.1", rx_versionPTP_o, rx_minorVersionPTP_o); end
    n_checks++; if (int_rx_ptp_o !== 1'b1) begin n_fail++; $display("FAIL untagged int: got %b want 1", int_rx_ptp_o); end
  endtask

  task automatic test_vlan;
    sfd_timestamp_i = 80'h2_0000_0077;
    sfd_timestamp_frac_ns_i = 16'h0011;
    p0 = pulse_cnt;
    send_frame(1'b1, 16'h88F7, 8'h31, 8'h02, 16'h0400, 16'hBEEF, Spid2, 62, -1);
    send_idle(4);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL vlan pulses: got %0d want 1", pulse_cnt - p0); end
    n_checks++; if (rx_seqId_o !== 16'hBEEF) begin n_fail++; $display("FAIL vlan seqId: got %h want BEEF", rx_seqId_o); end
    n_checks++; if (rx_messageType_o !== 4'h1 || rx_majorSdoId_o !== 4'h3) begin n_fail++; $display("FAIL vlan byte0: got %h/%h want 1/3", rx_messageType_o, rx_majorSdoId_o); end
    n_checks++; if (rx_flagField_o !== 16'h0400) begin n_fail++; $display("FAIL vlan flag: got %h want 0400", rx_flagField_o); end
    n_checks++; if (rx_sourcePortIdentity_o !== Spid2) begin n_fail++; $display("FAIL vlan spid: got %h want %h", rx_sourcePortIdentity_o, Spid2); end
    n_checks++; if (rxts_timestamp_o !== 96'h2_0000_0077_0011) begin n_fail++; $display("FAIL vlan ts: got %h want %h", rxts_timestamp_o, 96'h2_0000_0077_0011); end
  endtask

  task automatic test_drop;
    p0 = pulse_cnt;
    send_frame(1'b0, 16'h0800, 8'h00, 8'h02, 16'h0, 16'h1111, Spid1, 60, -1);
    send_idle(2);
    send_frame(1'b0, 16'h88F7, 8'h00, 8'h02, 16'h0, 16'h2222, Spid1, 30, -1);
    send_idle(4);
    n_checks++; if (pulse_cnt - p0 != 0) begin n_fail++; $display("FAIL drop pulses: got %0d want 0", pulse_cnt - p0); end
    n_checks++; if (rx_seqId_o !== 16'hBEEF) begin n_fail++; $display("FAIL drop held seqId: got %h want BEEF", rx_seqId_o); end
    n_checks++; if (rx_sourcePortIdentity_o !== Spid2) begin n_fail++; $display("FAIL drop held spid: got %h want %h", rx_sourcePortIdentity_o, Spid2); end
  endtask

  task automatic test_event_only;
    event_only_i = 1'b1;
    p0 = pulse_cnt;
    send_frame(1'b0, 16'h88F7, 8'h08, 8'h02, 16'h0, 16'h5555, Spid1, 59, -1);
    send_idle(4);
    n_checks++; if (pulse_cnt - p0 != 0) begin n_fail++; $display("FAIL event_only blocked pulses: got %0d want 0", pulse_cnt - p0); end
    n_checks++; if (rx_seqId_o !== 16'hBEEF) begin n_fail++; $display("FAIL event_only held seqId: got %h want BEEF", rx_seqId_o); end
    event_only_i = 1'b0;
    send_frame(1'b0, 16'h88F7, 8'h08, 8'h02, 16'h0, 16'h5556, Spid1, 59, -1);
    send_idle(4);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL follow_up pulses: got %0d want 1", pulse_cnt - p0); end
    n_checks++; if (rx_messageType_o !== 4'h8 || rx_seqId_o !== 16'h5556) begin n_fail++; $display("FAIL follow_up fields: got %h/%h want 8/5556", rx_messageType_o, rx_seqId_o); end
  endtask

  task automatic test_back_to_back;
    p0 = pulse_cnt;
    send_frame(1'b0, 16'h88F7, 8'h00, 8'h02, 16'h0, 16'h7777, Spid1, 59, 20);
    send_frame(1'b0, 16'h88F7, 8'h00, 8'h02, 16'h0, 16'h8888, Spid2, 59, -1);
    send_idle(4);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL b2b pulses: got %0d want 1", pulse_cnt - p0); end
    n_checks++; if (rx_seqId_o !== 16'h8888) begin n_fail++; $display("FAIL b2b seqId: got %h want 8888", rx_seqId_o); end
  endtask

  task automatic test_clk_en;
    int_clr_i = 1'b1;
    @(posedge rx_clk); #1;
    int_clr_i = 1'b0;
    n_checks++; if (int_rx_ptp_o !== 1'b0) begin n_fail++; $display("FAIL int clear: got %b want 0", int_rx_ptp_o); end
    sfd_timestamp_i = 80'h1_0000_0005;
    sfd_timestamp_frac_ns_i = 16'hABCD;
    slow = 1'b1;
    p0 = pulse_cnt;
    send_frame(1'b0, 16'h88F7, 8'h00, 8'h12, 16'h0200, 16'h1234, Spid1, 59, -1);
    int_clr_i = 1'b1;
    @(negedge rx_clk);
    n_checks++; if (rxts_valid_o !== 1'b1) begin n_fail++; $display("FAIL slow pulse: valid %b want 1", rxts_valid_o); end
    @(posedge rx_clk); #1;
    int_clr_i = 1'b0;
    n_checks++; if (int_rx_ptp_o !== 1'b1) begin n_fail++; $display("FAIL int set-vs-clear: got %b want 1", int_rx_ptp_o); end
    send_idle(2);
    slow = 1'b0;
    send_idle(2);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL slow pulses: got %0d want 1", pulse_cnt - p0); end
    n_checks++; if (rx_seqId_o !== 16'h1234 || rx_flagField_o !== 16'h0200) begin n_fail++; $display("FAIL slow seq/flag: got %h/%h want 1234/0200", rx_seqId_o, rx_flagField_o); end
    n_checks++; if (rx_sourcePortIdentity_o !== Spid1) begin n_fail++; $display("FAIL slow spid: got %h want %h", rx_sourcePortIdentity_o, Spid1); end
    n_checks++; if (rxts_timestamp_o !== 96'h1_0000_0005_ABCD) begin n_fail++; $display("FAIL slow ts: got %h want %h", rxts_timestamp_o, 96'h1_0000_0005_ABCD); end
    n_checks++; if (int_rx_ptp_o !== 1'b1) begin n_fail++; $display("FAIL int held: got %b want 1", int_rx_ptp_o); end
    int_clr_i = 1'b1;
    @(posedge rx_clk); #1;
    int_clr_i = 1'b0;
    n_checks++; if (int_rx_ptp_o !== 1'b0) begin n_fail++; $display("FAIL int second clear: got %b want 0", int_rx_ptp_o); end
  endtask

  initial begin
    rx_rst = 1'b1;
    rx_clk_en_i = 1'b1;
    rxd_i = 64'h0707_0707_0707_0707;
    rxc_i = 8'hFF;
    sfd_timestamp_i = '0;
    sfd_timestamp_frac_ns_i = '0;
    rx_ptp_en_i = 1'b1;
    event_only_i = 1'b0;
    int_clr_i = 1'b0;
    test_reset;
    send_idle(2);
    test_untagged;
    test_vlan;
    test_drop;
    test_event_only;
    test_back_to_back;
    test_clk_en;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ptp_parse.md
Name: rx_ptp_parse

Overview:
Receive-side counterpart of the tx timestamp engine. It observes the XGMII receive stream and recognises PTPv2-over-Ethernet frames (EtherType 0x88F7, optionally behind one 802.1Q tag). For each accepted frame it latches the SFD timestamp and the PTP header identity fields, then presents them to the rx timestamp FIFO/CPU path with a one-cycle valid pulse and a sticky interrupt. It observes only and does not modify the data path.

Parameters:
VLAN_TPID, 16'h8100, TPID recognised as a single VLAN tag
PTP_ETYPE, 16'h88F7, EtherType identifying PTP over L2

Ports:
rx_clk  input  1  XGMII receive clock
rx_rst  input  1  asynchronous reset, active-high
rx_clk_en_i  input  1  word qualifier (gmii/mii adaptation); logic advances only when high
rxd_i  input  64  XGMII data, lane0 = [7:0] (first on wire)
rxc_i  input  8  XGMII control, bit n marks lane n
sfd_timestamp_i  input  80  {48b sec, 32b ns}, rx SFD time
sfd_timestamp_frac_ns_i  input  16  fractional ns
rx_ptp_en_i  input  1  parser enable
event_only_i  input  1  1: report only messageType < 8
int_clr_i  input  1  clears int_rx_ptp_o
rxts_valid_o  output  1  one-cycle result pulse
rxts_timestamp_o  output  96  {sec, ns, frac_ns} latched at start
rx_sourcePortIdentity_o  output  80  header bytes 20-29
rx_flagField_o  output  16  header bytes 6-7
rx_seqId_o  output  16  header bytes 30-31
rx_versionPTP_o  output  4  byte1[3:0]
rx_minorVersionPTP_o  output  4  byte1[7:4]
rx_messageType_o  output  4  byte0[3:0]
rx_majorSdoId_o  output  4  byte0[7:4]
int_rx_ptp_o  output  1  sticky interrupt

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0.
- All state and register updates are gated by rx_clk_en_i. rxts_valid_o is forced low in any cycle in which rx_clk_en_i is low.
- Start word: rxc_i=8'h01, rxd_i[7:0]=8'hFB, lanes 1-6 = 8'h55, lane7 = 8'hD5. Only a lane-0 start is supported; a start in lane 4 is ignored.
- On a start word with rx_ptp_en_i=1: latch {sfd_timestamp_i, sfd_timestamp_frac_ns_i} into a shadow register, clear the byte counter, go to HDR. A start seen in any non-IDLE state restarts parsing; the partial frame is discarded.
- Byte counter: frame byte 0 = first DA byte (word after start). The counter advances by 8 per accepted word and saturates at 127. A byte at index b is captured in the cycle its word arrives.
- HDR state:
  - Bytes 12-13 = PTP_ETYPE: header offset H=14, go to PTP.
  - Bytes 12-13 = VLAN_TPID and bytes 16-17 = PTP_ETYPE: H=18, go to PTP.
  - Any other value: go to DROP.
- PTP state: capture header fields at bytes H+0, H+1, H+6..7, H+20..29 and H+30..31 into shadow registers. Set hdr_done once byte H+31 has been captured.
- Terminate: any lane with rxc=1 and data 8'hFD.
  - Frame qualifies if state is PTP, hdr_done=1, no error was seen, and (event_only_i=0 or messageType<8).
  - If it qualifies: in the next enabled cycle, copy shadows to outputs and pulse rxts_valid_o for one cycle.
  - The state returns to IDLE regardless of whether the frame qualified.
- Error: any lane with rxc=1 and data 8'hFE, or any control lane other than the terminate in a non-IDLE state, sets a frame error. The state goes to DROP, which waits for a terminate, then IDLE without a pulse.
- Outputs hold their last reported values between pulses.
- int_rx_ptp_o: set on each rxts_valid_o pulse, cleared by int_clr_i. A simultaneous set and clear leaves it set.
- Dropping rx_ptp_en_i mid-frame returns the state to IDLE on the next enabled cycle without a pulse.
- Latency: pulse 1 enabled cycle after the terminate word. A terminate word carrying a new start word is not supported.

Test Plan:
- Untagged Sync frame (messageType 0, seqId 16'h1234, flagField 16'h0200, sourcePortIdentity 80'h0011_2233_4455_6677_8899), terminate in lane 3, timestamp 80'h1_0000_0005 at start -> one pulse, fields exact, rxts_timestamp_o[95:16]=80'h1_0000_0005, int_rx_ptp_o=1.
- VLAN-tagged Delay_Req (messageType 1, seqId 16'hBEEF) -> fields taken from offset 18, one pulse.
- EtherType 0x0800 frame, then a truncated PTP frame terminating at byte 30 -> no pulse, outputs unchanged.
- Follow_Up (messageType 8) with event_only_i=1 -> no pulse; with event_only_i=0 -> pulse.
- PTP frame carrying 8'hFE at byte 20 -> no pulse. A back-to-back valid frame afterwards -> pulse with the new seqId.
- rx_clk_en_i toggled 1-of-10 during a valid frame -> same fields as the full-rate run. int_clr_i asserted in the pulse cycle -> int_rx_ptp_o stays 1, then clears on the next int_clr_i.
